// File: rtl/int_to_float.sv
// int_to_float: four-stage pipelined signed-integer to floating-point converter.
//   stage 1: sign capture and magnitude
//   stage 2: leading-one search
//   stage 3: left-normalise onto the hidden bit
//   stage 4: round, exponent saturation/clamp and packing into out_data
// All stages advance together when the output is empty or being taken, so a
// stall at the sink freezes the whole pipe and nothing is dropped or repeated.
// Build option: define INT_TO_FLOAT_ROUND_EN for round-to-nearest, ties away
// from zero; without it the result is truncated toward zero.
module int_to_float #(
    parameter int MANTISSA_SIZE        = 23,
    parameter int EXPONENT_SIZE        = 8,
    parameter int INT_SIZE             = 32,
    parameter int EXPONENT_BIAS_OFFSET = 0
) (
    input  logic                                     clk,
    input  logic                                     resetn,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [INT_SIZE-1:0]                      in_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [EXPONENT_SIZE+MANTISSA_SIZE:0]     out_data
);

    localparam int PW  = $clog2(INT_SIZE);
    localparam int OW  = 1 + EXPONENT_SIZE + MANTISSA_SIZE;
    // Exponent arithmetic width: wide enough for p + bias + carry and a sign,
    // even for narrow exponent fields paired with wide integers.
    localparam int EXT = ((EXPONENT_SIZE > 7) ? EXPONENT_SIZE : 7) + 3;

    localparam logic signed [EXT-1:0] BIAS_EXT    = EXT'((2 ** (EXPONENT_SIZE - 1)) - 1);
    localparam logic signed [EXT-1:0] OFFSET_EXT  = EXT'(EXPONENT_BIAS_OFFSET);
    localparam logic signed [EXT-1:0] EXP_MAX_EXT = EXT'((2 ** EXPONENT_SIZE) - 2);
    localparam logic signed [EXT-1:0] EXP_MIN_EXT = EXT'(1);

    logic advance;

    logic                     s1_valid;
    logic                     s1_sign;
    logic [INT_SIZE-1:0]      s1_mag;

    logic                     s2_valid;
    logic                     s2_sign;
    logic                     s2_zero;
    logic [PW-1:0]            s2_pos;
    logic [INT_SIZE-1:0]      s2_mag;

    logic                     s3_valid;
    logic                     s3_sign;
    logic                     s3_zero;
    logic [PW-1:0]            s3_pos;
    logic [MANTISSA_SIZE-1:0] s3_mant;
`ifdef INT_TO_FLOAT_ROUND_EN
    logic                     s3_guard;
`endif

    logic [PW-1:0]            lead_pos;
    logic                     lead_zero;
    logic [PW-1:0]            shamt;
    logic [INT_SIZE-1:0]      norm;
    logic                     unused_norm_bits;

    logic [MANTISSA_SIZE:0]   mant_sum;
    logic signed [EXT-1:0]    exp_ext;
    logic [OW-1:0]            result;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage 1: sign and magnitude; the most negative input maps onto 2^(INT_SIZE-1).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_sign  <= in_data[INT_SIZE-1];
            s1_mag   <= in_data[INT_SIZE-1] ? (~in_data + INT_SIZE'(1)) : in_data;
        end
    end

    // Leading-one search: the highest set bit wins.
    always_comb begin
        lead_pos  = '0;
        lead_zero = (s1_mag == '0);
        for (int i = 0; i < INT_SIZE; i++) begin
            if (s1_mag[i]) lead_pos = PW'(i);
        end
    end

    // Stage 2: register the leading-one position alongside the magnitude.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_zero  <= 1'b0;
            s2_pos   <= '0;
            s2_mag   <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_zero  <= lead_zero;
            s2_pos   <= lead_pos;
            s2_mag   <= s1_mag;
        end
    end

    // Normalise so the leading one lands on the MSB; the hidden bit itself and
    // the bits below the guard position are not needed further down.
    assign shamt            = PW'(INT_SIZE - 1) - s2_pos;
    assign norm             = s2_mag << shamt;
    assign unused_norm_bits = ^{norm[INT_SIZE-1], norm[INT_SIZE-2-MANTISSA_SIZE:0]};

    // Stage 3: keep the stored mantissa bits and, when rounding, the guard bit.
    // Ties-away rounding decides on the guard bit alone, so no sticky is kept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s3_valid <= 1'b0;
            s3_sign  <= 1'b0;
            s3_zero  <= 1'b0;
            s3_pos   <= '0;
            s3_mant  <= '0;
`ifdef INT_TO_FLOAT_ROUND_EN
            s3_guard <= 1'b0;
`endif
        end else if (advance) begin
            s3_valid <= s2_valid;
            s3_sign  <= s2_sign;
            s3_zero  <= s2_zero;
            s3_pos   <= s2_pos;
            s3_mant  <= norm[INT_SIZE-2 -: MANTISSA_SIZE];
`ifdef INT_TO_FLOAT_ROUND_EN
            s3_guard <= norm[INT_SIZE-2-MANTISSA_SIZE];
`endif
        end
    end

    // Round, fold any mantissa carry into the exponent, then saturate or clamp.
    always_comb begin
`ifdef INT_TO_FLOAT_ROUND_EN
        mant_sum = {1'b0, s3_mant} + (MANTISSA_SIZE + 1)'(s3_guard);
`else
        mant_sum = {1'b0, s3_mant};
`endif
        exp_ext = $signed(EXT'(s3_pos)) + BIAS_EXT + OFFSET_EXT
                + $signed(EXT'(mant_sum[MANTISSA_SIZE]));
        if (s3_zero) begin
            result = '0;
        end else if (exp_ext > EXP_MAX_EXT) begin
            result = {s3_sign, {EXPONENT_SIZE{1'b1}}, {MANTISSA_SIZE{1'b0}}};
        end else if (exp_ext < EXP_MIN_EXT) begin
            result = {s3_sign, {(OW - 1){1'b0}}};
        end else begin
            result = {s3_sign, exp_ext[EXPONENT_SIZE-1:0], mant_sum[MANTISSA_SIZE-1:0]};
        end
    end

    // Stage 4: registered output word and its valid flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (advance) begin
            out_valid <= s3_valid;
            out_data  <= result;
        end
    end

endmodule

// File: tb/tb_int_to_float.sv
// Directed bench for int_to_float. Three instances run in lockstep on the same
// stimulus: default single precision, a bias offset of -1, and a narrow
// 16-bit format (5-bit exponent) that reaches exponent saturation easily.
module tb_int_to_float;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;

    logic        in_ready_a, out_valid_a;
    logic [31:0] out_data_a;
    logic        in_ready_b, out_valid_b;
    logic [31:0] out_data_b;
    logic        in_ready_c, out_valid_c;
    logic [15:0] out_data_c;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] q[$];
    bit          rec_en = 1'b0;

`ifdef INT_TO_FLOAT_ROUND_EN
    localparam logic [31:0] A_7FFF = 32'h4F000000, B_7FFF = 32'h4E800000;
    localparam logic [31:0] A_2P24 = 32'h4B800001, B_2P24 = 32'h4B000001;
    localparam logic [31:0] A_1FF  = 32'h4C000000, B_1FF  = 32'h4B800000;
    localparam logic [15:0] C_FFF  = 16'h6C00;
`else
    localparam logic [31:0] A_7FFF = 32'h4EFFFFFF, B_7FFF = 32'h4E7FFFFF;
    localparam logic [31:0] A_2P24 = 32'h4B800000, B_2P24 = 32'h4B000000;
    localparam logic [31:0] A_1FF  = 32'h4BFFFFFF, B_1FF  = 32'h4B7FFFFF;
    localparam logic [15:0] C_FFF  = 16'h6BFF;
`endif

    int_to_float u_dut_a (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a)
    );

    int_to_float #(.EXPONENT_BIAS_OFFSET(-1)) u_dut_b (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b)
    );

    int_to_float #(.MANTISSA_SIZE(10), .EXPONENT_SIZE(5), .INT_SIZE(32)) u_dut_c (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c)
    );

    always #5 clk = ~clk;

    // Record every result the sink takes, sampled mid-cycle.
    always @(negedge clk) begin
        if (rec_en && out_valid_a && out_ready) q.push_back(out_data_a);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated conversion: accept, wait for the result, check latency and data.
    task automatic run_vec(input string tag, input logic [31:0] d,
                           input logic [31:0] ea, input logic [31:0] eb,
                           input logic [15:0] ec);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid_a && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd4);
        check({tag, " a"}, 64'(out_data_a), 64'(ea));
        check({tag, " b"}, 64'(out_data_b), 64'(eb));
        check({tag, " c"}, 64'(out_data_c), 64'(ec));
        tick();
    endtask

    initial begin
        logic [31:0] exp_stream [8];
        int          sent;
        int          t;
        int          stale;
        bit          saw_stall;

        exp_stream = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                       32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

        // Reset state.
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        #3;
        check("reset out_valid", 64'(out_valid_a), 64'd0);
        check("reset out_data", 64'(out_data_a), 64'd0);
        check("reset in_ready", 64'(in_ready_a), 64'd1);
        tick();
        tick();
        resetn = 1'b1;
        check("release in_ready", 64'(in_ready_a), 64'd1);

        // Back-to-back 1, -1, 0 with results on cycles 4, 5, 6.
        in_valid = 1'b1;
        in_data  = 32'd1;
        tick();
        in_data = 32'hFFFFFFFF;
        tick();
        in_data = 32'd0;
        tick();
        in_valid = 1'b0;
        check("b2b cycle3 valid", 64'(out_valid_a), 64'd0);
        tick();
        check("b2b cycle4 valid", 64'(out_valid_a), 64'd1);
        check("b2b cycle4 data", 64'(out_data_a), 64'h3F800000);
        tick();
        check("b2b cycle5 data", 64'(out_data_a), 64'hBF800000);
        tick();
        check("b2b cycle6 valid", 64'(out_valid_a), 64'd1);
        check("b2b cycle6 data", 64'(out_data_a), 64'h00000000);
        tick();
        check("b2b cycle7 valid", 64'(out_valid_a), 64'd0);

        // Isolated conversions.
        run_vec("min_int",  32'h80000000, 32'hCF000000, 32'hCE800000, 16'hFC00);
        run_vec("max_int",  32'h7FFFFFFF, A_7FFF,       B_7FFF,       16'h7C00);
        run_vec("2p24p1",   32'd16777217, A_2P24,       B_2P24,       16'h7C00);
        run_vec("2p24",     32'd16777216, 32'h4B800000, 32'h4B000000, 16'h7C00);
        run_vec("exact_p23",32'h00FFFFFF, 32'h4B7FFFFF, 32'h4AFFFFFF, 16'h7C00);
        run_vec("carry",    32'h01FFFFFF, A_1FF,        B_1FF,        16'h7C00);
        run_vec("three",    32'd3,        32'h40400000, 32'h3FC00000, 16'h4200);
        run_vec("neg_six",  32'hFFFFFFFA, 32'hC0C00000, 32'hC0400000, 16'hC600);
        run_vec("c_maxexp", 32'h00008000, 32'h47000000, 32'h46800000, 16'h7800);
        run_vec("c_inf",    32'h00100000, 32'h49800000, 32'h49000000, 16'h7C00);
        run_vec("c_ninf",   32'hFFF00000, 32'hC9800000, 32'hC9000000, 16'hFC00);
        run_vec("zero",     32'd0,        32'h00000000, 32'h00000000, 16'h0000);
        run_vec("c_exact",  32'h000007FF, 32'h44FFE000, 32'h447FE000, 16'h67FF);
        run_vec("c_carry",  32'h00000FFF, 32'h457FF000, 32'h44FFF000, C_FFF);

        // Stream 1..8 with a 3-cycle sink stall in the middle.
        q.delete();
        rec_en    = 1'b1;
        sent      = 0;
        t         = 0;
        saw_stall = 1'b0;
        while ((sent < 8 || q.size() < 8) && t < 200) begin
            out_ready = !(t >= 5 && t < 8);
            in_valid  = (sent < 8);
            in_data   = 32'(sent + 1);
            #1;
            if (!in_ready_a && out_valid_a) saw_stall = 1'b1;
            if (in_valid && in_ready_a) sent++;
            @(posedge clk);
            #1;
            t++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rec_en    = 1'b0;
        check("stream stall seen", 64'(saw_stall), 64'd1);
        check("stream count", 64'(q.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < q.size()) check($sformatf("stream[%0d]", i), 64'(q[i]), 64'(exp_stream[i]));
            else              check($sformatf("stream[%0d] missing", i), 64'd0, 64'(exp_stream[i]));
        end
        repeat (4) tick();

        // Reset with results in flight.
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 32'(i);
            tick();
        end
        in_valid = 1'b0;
        check("flight out_valid", 64'(out_valid_a), 64'd1);
        resetn = 1'b0;
        #1;
        check("mid reset out_valid", 64'(out_valid_a), 64'd0);
        check("mid reset out_data", 64'(out_data_a), 64'd0);
        check("mid reset in_ready", 64'(in_ready_a), 64'd1);
        tick();
        tick();
        resetn = 1'b1;
        check("post reset in_ready", 64'(in_ready_a), 64'd1);
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid_a || out_valid_b || out_valid_c) stale++;
            tick();
        end
        check("no stale results", 64'(stale), 64'd0);
        run_vec("after_reset", 32'd5, 32'h40A00000, 32'h40200000, 16'h4500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/int_to_float.md
INT_TO_FLOAT -- requirements
Module: IntToFloat

Interface
- REQ-001 SHALL have parameter MANTISSA_SIZE, default 23, meaning the stored mantissa width without the hidden bit.
- REQ-002 SHALL have parameter EXPONENT_SIZE, default 8, meaning the biased exponent width.
- REQ-003 SHALL have parameter INT_SIZE, default 32, meaning the signed two's-complement input width; the legal range is MANTISSA_SIZE+2 to 64.
- REQ-004 SHALL have parameter EXPONENT_BIAS_OFFSET, default 0, meaning an added bias shift; -1 divides the result by 2.0, -2 divides it by 4.0 (fixed-point input).
- REQ-005 SHALL have ports, in order:
  - clk  input  1  clock; all logic runs on the rising edge.
  - resetn  input  1  reset; asynchronous assert, active-low.
  - in_valid  input  1  the input word is valid.
  - in_ready  output  1  the block accepts an input this cycle.
  - in_data  input  INT_SIZE  signed integer.
  - out_valid  output  1  out_data holds a result.
  - out_ready  input  1  the sink accepts the result.
  - out_data  output  1+EXPONENT_SIZE+MANTISSA_SIZE  float as {sign, exponent, mantissa}.

Function
- REQ-006 SHALL be a 4-stage pipeline with stall: advance = !out_valid || out_ready.
- REQ-007 SHALL drive in_ready = advance combinationally; an input transfers when in_valid && in_ready.
- REQ-008 SHALL move every stage register and its valid bit only when advance=1; on a stall all stages hold.
- REQ-009 SHALL present a result on out_valid exactly 4 cycles after it is accepted, when there is no stall.
- REQ-010 SHALL sustain a throughput of 1 conversion per clock.
- REQ-011 SHALL keep results in the same order as the inputs; it SHALL NOT drop or duplicate any result under any out_ready pattern.
- REQ-012, stage 1 SHALL capture the sign and take magnitude = |in_data| as an unsigned INT_SIZE value; -2^(INT_SIZE-1) gives 2^(INT_SIZE-1) with no overflow.
- REQ-013, stage 2 SHALL compute the leading-one position p of the magnitude and a zero flag.
- REQ-014, stage 3 SHALL left-normalise the magnitude so that bit p sits at the hidden-bit position, keeping the guard bit and the sticky-OR of the bits below it.
- REQ-015, stage 4 SHALL round and then pack the result:
  - exponent = p + 2^(EXPONENT_SIZE-1) - 1 + EXPONENT_BIAS_OFFSET;
  - mantissa = the normalised bits below the hidden bit.
- REQ-016 SHALL increment the exponent and clear the mantissa if a rounding carry overflows the mantissa.
- REQ-017 SHALL produce out_data = all zeros (+0.0) for in_data = 0, with no exponent term.
- REQ-018 SHALL produce an exact result with no rounding when p <= MANTISSA_SIZE.
- REQ-019 SHALL saturate to the maximum-exponent value with a zero mantissa (infinity) if the biased exponent exceeds 2^EXPONENT_SIZE-2; it SHALL clamp to zero if the exponent falls below 1 because of a negative EXPONENT_BIAS_OFFSET.

Reset
- REQ-020 SHALL clear all stage valid bits, out_valid and out_data to 0 immediately while resetn=0.
- REQ-021 SHALL discard any data in flight when reset asserts mid-operation; no stale result SHALL appear after release.
- REQ-022 SHALL drive in_ready=1 during reset and on the first cycle after release.

Configuration
- REQ-023 With macro INT_TO_FLOAT_ROUND_EN defined, SHALL round to nearest with ties away from zero: add 1 to the mantissa when the guard bit is 1.
- REQ-024 With INT_TO_FLOAT_ROUND_EN undefined, SHALL truncate toward zero; the guard and sticky logic SHALL be removed and latency SHALL stay 4 cycles.

Verification
- REQ-025 Default parameters, out_ready=1: inputs 1, -1, 0 on consecutive cycles -> 0x3F800000, 0xBF800000, 0x00000000 on cycles 4, 5, 6.
- REQ-026 in_data=0x80000000 -> 0xCF000000; in_data=0x7FFFFFFF -> 0x4F000000 (ROUND_EN) or 0x4EFFFFFF (no macro).
- REQ-027 in_data=16777217 -> 0x4B800001 (ROUND_EN, tie away) or 0x4B800000 (no macro); in_data=16777216 -> 0x4B800000 in both builds.
- REQ-028 Stream 1..8 with out_ready held low for 3 cycles mid-stream -> in_ready falls while out_valid=1; outputs equal the floats of 1..8 in order with none lost.
- REQ-029 resetn pulsed low with 3 results in flight -> out_valid=0 and out_data=0 at once; no output until a new input is accepted 4 cycles earlier.
- REQ-030 EXPONENT_BIAS_OFFSET=-1, in_data=3 -> 0x3FC00000 (1.5).
